// File: rtl/dm_pkg.sv
// Shared types for the data-memory responder: controller state, write-log record
// and the byte-lane merge used for partial-word stores.
package dm_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } log_rec_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dm_responder_if.sv
// Core data port plus write-log drain handshake of the data-memory responder.
interface dm_responder_if;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_inst_addr;
  logic [31:0] m_data_rdata;
  logic        mem_ready;
  logic        log_valid;
  logic        log_ready;
  logic [31:0] log_pc;
  logic [31:0] log_addr;
  logic [31:0] log_data;
  logic        log_overflow;
  logic        addr_err;

  modport slave (
    input  m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr, log_ready,
    output m_data_rdata, mem_ready, log_valid, log_pc, log_addr, log_data,
           log_overflow, addr_err
  );

  modport master (
    output m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr, log_ready,
    input  m_data_rdata, mem_ready, log_valid, log_pc, log_addr, log_data,
           log_overflow, addr_err
  );
endinterface

// File: rtl/wlog_fifo.sv
// Synchronous FIFO for write-log records; a push into a full FIFO is accepted
// only when a pop frees the slot in the same cycle, otherwise it is dropped.
module wlog_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 96
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             drop
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
               (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    drop     = push && !do_push;
    wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    // Head reads as zero when empty so stale storage never leaks out.
    dout     = empty ? '0 : store[rd_ptr_q[PW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && do_push) store[wr_ptr_q[PW-1:0]] <= din;
  end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: word array with byte-enabled writes, combinational reads,
// a post-reset clear sequencer and a log of every committed write.
module dm_responder
  import dm_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int LOG_DEPTH = 8
) (
  input logic           clk,
  input logic           reset,
  dm_responder_if.slave bus
);
  localparam int WORDS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] IDX_ONE = 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic              addr_err_q, addr_err_d;
  logic              ovf_q, ovf_d;

  logic [31:0]       ram [WORDS];
  logic [ADDR_W-1:0] widx, ram_widx;
  logic [31:0]       rd_word, merged, ram_wdata;
  logic              in_range, wr_en, ram_we, is_ready;

  log_rec_t          push_rec, head_rec;
  logic              fifo_full, fifo_empty, fifo_drop, log_pop;

  assign widx     = bus.m_data_addr[ADDR_W+1:2];
  assign in_range = (bus.m_data_addr >> (ADDR_W + 2)) == 32'd0;
  assign rd_word  = ram[widx];
  assign merged   = merge_bytes(rd_word, bus.m_data_wdata, bus.m_data_byteen);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= CLEAR;
    else        state_q <= state_d;
  end

  // Next state: leave CLEAR once the last word has been zeroed
  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR:   if (clr_idx_q == '1) state_d = READY;
      READY:   state_d = READY;
      default: state_d = CLEAR;
    endcase
  end

  // Outputs and datapath controls
  always_comb begin
    is_ready   = (state_q == READY);
    wr_en      = is_ready && in_range && (bus.m_data_byteen != 4'b0000);
    clr_idx_d  = is_ready ? '0 : clr_idx_q + IDX_ONE;
    ram_we     = !is_ready || wr_en;
    ram_widx   = is_ready ? widx   : clr_idx_q;
    ram_wdata  = is_ready ? merged : 32'd0;
    addr_err_d = addr_err_q || (is_ready && !in_range);
    ovf_d      = ovf_q || fifo_drop;
    log_pop    = !fifo_empty && bus.log_ready;
    push_rec   = '{pc: bus.m_inst_addr, addr: {bus.m_data_addr[31:2], 2'b00}, data: merged};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      clr_idx_q  <= '0;
      addr_err_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      clr_idx_q  <= clr_idx_d;
      addr_err_q <= addr_err_d;
      ovf_q      <= ovf_d;
    end
  end

  // Array contents are not reset; the clear sequencer zeroes them instead.
  always_ff @(posedge clk) begin
    if (reset && ram_we) ram[ram_widx] <= ram_wdata;
  end

  wlog_fifo #(
    .DEPTH (LOG_DEPTH),
    .WIDTH ($bits(log_rec_t))
  ) u_wlog (
    .clk   (clk),
    .rst_n (reset),
    .push  (wr_en),
    .din   (push_rec),
    .pop   (log_pop),
    .dout  (head_rec),
    .full  (fifo_full),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

  assign bus.m_data_rdata = (is_ready && in_range) ? rd_word : 32'd0;
  assign bus.mem_ready    = is_ready;
  assign bus.log_valid    = !fifo_empty;
  assign bus.log_pc       = head_rec.pc;
  assign bus.log_addr     = head_rec.addr;
  assign bus.log_data     = head_rec.data;
  assign bus.log_overflow = ovf_q;
  assign bus.addr_err     = addr_err_q;

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_dm_responder.sv
// Randomised and directed checks of dm_responder against a word-array / record-queue model.
module tb_dm_responder;
  localparam int WORDS = 4096;
  localparam int DEPTH = 8;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } rec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dm_responder_if bus();

  dm_responder #(.ADDR_W(12), .LOG_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] mem_m [WORDS];
  rec_t sb_q[$];
  int   cnt_m;
  bit   ovf_m, aerr_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (mem_m[i]) mem_m[i] = 32'd0;
    sb_q.delete();
    cnt_m  = 0;
    ovf_m  = 1'b0;
    aerr_m = 1'b0;
  endtask

  // One READY-state cycle: drive, check outputs mid-cycle, then advance the model at the edge.
  task automatic cycle(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                       input logic [31:0] pc, input bit rdy);
    logic [31:0] new_w;
    bit inr, popm;
    bus.m_data_addr   = a;
    bus.m_data_wdata  = wd;
    bus.m_data_byteen = be;
    bus.m_inst_addr   = pc;
    bus.log_ready     = rdy;
    inr = (a < 32'h4000);
    @(negedge clk);
    chk("rdata", bus.m_data_rdata, inr ? mem_m[a[13:2]] : 32'd0);
    chk("mem_ready", bus.mem_ready, 1);
    chk("log_valid", bus.log_valid, cnt_m > 0);
    chk("log_overflow", bus.log_overflow, ovf_m);
    chk("addr_err", bus.addr_err, aerr_m);
    @(posedge clk);
    popm = (cnt_m > 0) && rdy;
    if (!inr) aerr_m = 1'b1;
    else if (be != 4'b0000) begin
      new_w = mem_m[a[13:2]];
      for (int i = 0; i < 4; i++) if (be[i]) new_w[8*i +: 8] = wd[8*i +: 8];
      mem_m[a[13:2]] = new_w;
      if (cnt_m - int'(popm) < DEPTH) begin
        sb_q.push_back('{pc, {a[31:2], 2'b00}, new_w});
        cnt_m++;
      end else ovf_m = 1'b1;
    end
    if (popm) cnt_m--;
    #1;
  endtask

  // Run the clear phase while hammering a write that must be ignored; n = cycles until mem_ready.
  task automatic run_clear(input int limit, output int n);
    n = 0;
    bus.m_data_addr   = 32'h10;
    bus.m_data_wdata  = 32'hFFFF_FFFF;
    bus.m_data_byteen = 4'hF;
    bus.m_inst_addr   = 32'h00BA_D000;
    bus.log_ready     = 1'b1;
    while (n < limit) begin
      @(negedge clk);
      chk("clear_mem_ready", bus.mem_ready, 0);
      chk("clear_rdata", bus.m_data_rdata, 0);
      @(posedge clk);
      #1;
      n++;
      if (bus.mem_ready) break;
    end
    bus.m_data_byteen = 4'h0;
    bus.log_ready     = 1'b0;
  endtask

  // Scoreboard monitor: every accepted head must match the oldest expected record.
  always @(negedge clk) begin
    rec_t e;
    if (bus.log_valid === 1'b1 && bus.log_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL log_pop: unexpected record pc %h addr %h data %h", bus.log_pc, bus.log_addr, bus.log_data);
      end else begin
        e = sb_q.pop_front();
        chk("log_pc", bus.log_pc, e.pc);
        chk("log_addr", bus.log_addr, e.addr);
        chk("log_data", bus.log_data, e.data);
      end
    end
  end

  initial begin
    int n;
    bus.m_data_addr = '0; bus.m_data_wdata = '0; bus.m_data_byteen = '0;
    bus.m_inst_addr = '0; bus.log_ready = 1'b0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_ready", bus.mem_ready, 0);
    chk("rst_log_valid", bus.log_valid, 0);
    chk("rst_log_pc", bus.log_pc, 0);
    chk("rst_log_addr", bus.log_addr, 0);
    chk("rst_log_data", bus.log_data, 0);
    chk("rst_overflow", bus.log_overflow, 0);
    chk("rst_addr_err", bus.addr_err, 0);
    chk("rst_rdata", bus.m_data_rdata, 0);

    reset = 1'b1;
    run_clear(5000, n);
    chk("clear_cycles", n, WORDS);
    model_reset();

    cycle(32'h10, 0, 4'h0, 0, 1'b0);
    cycle(32'h100, 32'h1234_5678, 4'b1111, 32'h0040_0000, 1'b1);
    cycle(32'h100, 32'h0000_AB00, 4'b0010, 32'h0040_0004, 1'b1);
    cycle(32'h100, 0, 4'h0, 0, 1'b1);
    chk("merged_0x100", bus.m_data_rdata, 32'h1234_AB78);

    cycle(32'h200, 32'hDEAD_BEEF, 4'hF, 32'h0040_0010, 1'b1);
    cycle(32'h200, 0, 4'h0, 0, 1'b1);
    chk("post_write_0x200", bus.m_data_rdata, 32'hDEAD_BEEF);
    repeat (3) cycle(32'h0, 0, 4'h0, 0, 1'b1);

    for (int i = 0; i < 9; i++)
      cycle(32'h300 + 4 * i, $urandom, 4'hF, 32'h0040_1000 + 4 * i, 1'b0);
    cycle(32'h300, 0, 4'h0, 0, 1'b0);
    chk("full_overflow", bus.log_overflow, 1);
    chk("full_head_pc", bus.log_pc, 32'h0040_1000);
    for (int i = 0; i < 8; i++) cycle(32'h300 + 4 * i, 0, 4'h0, 0, 1'b1);
    cycle(32'h320, 0, 4'h0, 0, 1'b1);
    chk("drained_valid", bus.log_valid, 0);

    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 63) * 4 + $urandom_range(0, 3), $urandom, 4'($urandom_range(0, 15)),
            $urandom, $urandom_range(0, 3) != 0);
    repeat (12) cycle(32'h0, 0, 4'h0, 0, 1'b1);

    cycle(32'h0000_4000, 32'hCAFE_F00D, 4'hF, 32'h0040_2000, 1'b1);
    cycle(32'h0, 0, 4'h0, 0, 1'b1);
    chk("oor_addr_err", bus.addr_err, 1);
    for (int i = 0; i < 4; i++)
      cycle(32'h4000 + $urandom_range(0, 32'h0FFF_0000), $urandom, 4'hF, $urandom, 1'b1);
    repeat (3) cycle(32'h0, 0, 4'h0, 0, 1'b1);

    bus.log_ready = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    run_clear(1000, n);
    chk("partial_clear", n, 1000);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    run_clear(5000, n);
    chk("reclear_cycles", n, WORDS);
    model_reset();
    cycle(32'h100, 0, 4'h0, 0, 1'b1);
    cycle(32'h200, 0, 4'h0, 0, 1'b1);
    cycle(32'h10, 0, 4'h0, 0, 1'b1);
    chk("final_scoreboard", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_responder.md
# dm_responder

Data-memory responder for the pipelined MIPS core: the memory-side end of the core's M-stage data port (byte address, write data, byte enables, returned read data). It holds word-addressed storage, performs byte-enabled writes on the clock edge, and returns read data combinationally in the same cycle. It also logs every committed write into a small FIFO for the grading and trace harness, which drains the FIFO through a valid/ready handshake. After reset, a clear sequencer zeroes the whole array before the block accepts traffic.

## Interface
Parameters:
- ADDR_W, 12, word-address width; the array holds 2^ADDR_W 32-bit words.
- LOG_DEPTH, 8, depth of the write-log FIFO in records; must be a power of two and at least 2.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low; reset==0 sampled at a rising edge resets the block.
- m_data_addr  in  32  byte address from the core; bits [1:0] are ignored.
- m_data_wdata  in  32  write data, aligned to the byte lanes.
- m_data_byteen  in  4  byte-lane write enables; 4'b0000 means read only.
- m_inst_addr  in  32  M-stage PC, recorded in the log.
- m_data_rdata  out  32  combinational read data.
- mem_ready  out  1  high once the clear sequence has finished.
- log_valid  out  1  FIFO head is valid.
- log_ready  in  1  harness accepts the FIFO head.
- log_pc, log_addr, log_data  out  32 each  head record: PC, word-aligned address, and the merged word after the write.
- log_overflow  out  1  sticky; a record was dropped.
- addr_err  out  1  sticky; an out-of-range access occurred.

## Operation
- States: CLEAR and READY. The state register, clear index, FIFO and sticky flags live in flops; the array contents do not reset.
- When reset is sampled low: go to CLEAR, set clear index to 0, empty the FIFO, clear both sticky flags.
- In CLEAR, each cycle with reset high: write 0 to word[index], then increment the index. After word 2^ADDR_W−1 is written, enter READY.
- In CLEAR: mem_ready=0, m_data_rdata=0, all core writes are ignored, and no log records are pushed.
- Word index = m_data_addr[ADDR_W+1:2]. The access is in range when m_data_addr < 4·2^ADDR_W.
- Read (READY, in range): m_data_rdata = word[index], combinational. Out of range: 0.
- Write (READY, in range, byteen≠0): lane i is replaced with wdata[8i+7:8i] where byteen[i]=1; other lanes keep their value.
- A committed write pushes one record: {m_inst_addr, m_data_addr with [1:0] cleared, merged word}.
- Out of range with byteen≠0 in READY: no write, no log record, addr_err←1. An out-of-range read also sets addr_err.
- Writes with byteen=0 are never logged.

## Timing
- Reset values: mem_ready=0, log_valid=0, log_pc/log_addr/log_data=0, log_overflow=0, addr_err=0, m_data_rdata=0.
- mem_ready rises exactly 2^ADDR_W cycles after the first rising edge at which reset is sampled high.
- Read latency is 0 cycles. A write lands at the edge; a read of the same word in the same cycle returns the old value, and the next cycle returns the new value.
- Log handshake: a pop occurs at an edge where log_valid && log_ready. A record pushed at edge N is visible at the head at N+1 if the FIFO was empty.
- FIFO full with a push and no pop: the memory write is still performed, the record is dropped, and log_overflow←1.
- FIFO full with a push and a pop in the same cycle: both occur, with no overflow. FIFO empty with a push and log_ready=1: the pop waits until the next cycle.
- Head fields stay stable while log_valid && !log_ready. FIFO pointers wrap modulo LOG_DEPTH, with one extra bit to tell full from empty.
- Reset asserted mid-clear or mid-traffic restarts the clear from index 0 and discards pending records.

## Structure
- Package dm_pkg: state enum {CLEAR, READY}, the log record struct (pc, addr, data), and the byte-merge function.
- Sub-module wlog_fifo: parameterised synchronous FIFO with push/pop/full/empty, reset active-low synchronous.
- The top level holds the array, the clear sequencer, range checking and the flags.

## Test plan
- Reset low for 2 cycles, then high → mem_ready=0 for exactly 4096 cycles, then 1. Reading 0x00000010 returns 0 and no log records appear.
- Write 0x12345678 with byteen 4'b1111 to 0x100, then write 0x0000AB00 with byteen 4'b0010 to 0x100 → rdata at 0x100 = 0x1234AB78. The log holds 0x12345678 then 0x1234AB78, with pc values as driven.
- Same-cycle write and read at 0x200 (old value 0, new 0xDEADBEEF) → rdata=0 that cycle and 0xDEADBEEF the next.
- Nine writes with log_ready=0 → log_valid=1, the first 8 records are retained, log_overflow=1, and all 9 words are present in memory. Then drain with log_ready=1 for 8 cycles → log_valid=0.
- Write to 0x00004000 with byteen 4'b1111 → addr_err=1, rdata=0, no log record, memory unchanged.
- Assert reset during clear at index 1000 → the clear restarts, and mem_ready rises 4096 cycles after reset is released.
